subpel_interp_8x8: RTL and testbench

- HEVC luma sub-pixel interpolator for one 8x8 block.
- Reads a 15x15 block of 8-bit integer pixels one row per cycle. This is the 8x8 block plus a 3-left/3-top and 4-right/4-bottom margin.
- Produces all 15 fractional positions using the HEVC 8-tap quarter, half and three-quarter filters.
- Sits after the reference-frame fetch buffer. It drives the row index and receives the row combinationally.

---
 rtl/subpel_pkg.sv | 40 ++++
 rtl/subpel_interp_8x8_fir8.sv | 21 ++
 rtl/subpel_interp_8x8.sv | 134 +++++++++++++
 tb/tb_subpel_interp_8x8.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/subpel_pkg.sv
// rtl/subpel_pkg.sv - shared parameters, coefficients, states and rounding for the 8x8 sub-pel interpolator
package subpel_pkg;

    localparam int PIX_W = 8;
    localparam int BLK   = 8;
    localparam int TAPS  = 8;

    typedef logic signed [7:0] coef_arr_t [TAPS];

    // Quarter, half and three-quarter luma filters; tap i multiplies window sample i.
    localparam coef_arr_t COEF_A = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
    localparam coef_arr_t COEF_B = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
    localparam coef_arr_t COEF_C = '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};

    typedef enum logic [1:0] {LOAD, VERT, DONE} state_t;

    // Coefficient for a phase (0=a, 1=b, 2/3=c), sign-extended to the accumulator width.
    function automatic logic signed [15:0] coef(input logic [1:0] phase, input int tap);
        logic signed [7:0] c;
        case (phase)
            2'd0:    c = COEF_A[tap];
            2'd1:    c = COEF_B[tap];
            default: c = COEF_C[tap];
        endcase
        return {{8{c[7]}}, c};
    endfunction

    // Round by 1/2 LSB of the 6-bit normalisation, arithmetic shift, then clip to the pixel range.
    function automatic logic [PIX_W-1:0] round_clip(input logic signed [15:0] sum);
        logic signed [15:0] r;
        r = (sum + 16'sd32) >>> 6;
        if (r < 16'sd0)
            return '0;
        else if (r > 16'sd255)
            return '1;
        else
            return r[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/subpel_interp_8x8_fir8.sv
// rtl/subpel_interp_8x8_fir8.sv - one 8-tap filter: window (8 pixels), phase select, clipped pixel out
module subpel_fir8
    import subpel_pkg::*;
(
    input  logic [TAPS*PIX_W-1:0] window,
    input  logic [1:0]            phase,
    output logic [PIX_W-1:0]      pix
);

    logic signed [15:0] sum;

    // Worst-case magnitude is 255*88, so 16 signed bits never wrap.
    always_comb begin
        sum = '0;
        for (int t = 0; t < TAPS; t++) begin
            sum = sum + $signed({{(16-PIX_W){1'b0}}, window[PIX_W*t +: PIX_W]}) * coef(phase, t);
        end
        pix = round_clip(sum);
    end

endmodule

// File: rtl/subpel_interp_8x8.sv
// rtl/subpel_interp_8x8.sv - 8x8 luma sub-pel interpolator: 15 row loads, 32 vertical steps, then done
// Ports: clk/rst (async active-low); in_row = 15 pixels of row next_row; out_A/B/C = 40 result rows each;
// cnt = step counter; fir_out_a/b/c = live filter bank outputs; temp_A/B/C = horizontal rows 0..14;
// load_out = results valid; sel = vertical source (0 int, 1 A, 2 B, 3 C); currentPixels = last loaded row.
module subpel_interp_8x8
    import subpel_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic [(BLK+TAPS-1)*PIX_W-1:0]      in_row,
    output logic [63:0]                        next_row,
    output logic [2559:0]                      out_A,
    output logic [2559:0]                      out_B,
    output logic [2559:0]                      out_C,
    output logic [7:0]                         cnt,
    output logic [BLK*PIX_W-1:0]               fir_out_a,
    output logic [BLK*PIX_W-1:0]               fir_out_b,
    output logic [BLK*PIX_W-1:0]               fir_out_c,
    output logic [959:0]                       temp_A,
    output logic [959:0]                       temp_B,
    output logic [959:0]                       temp_C,
    output logic                               load_out,
    output logic [7:0]                         sel,
    output logic [(BLK+TAPS-1)*PIX_W-1:0]      currentPixels
);

    localparam int ROW_W = BLK * PIX_W;

    state_t             state;
    logic [959:0]       int_rows;   // integer columns 3..10 of each loaded row
    logic [4:0]         j;          // vertical step index, meaningful only in VERT
    logic [1:0]         sel_v;
    logic [2:0]         y;
    logic [ROW_W-1:0]   win [BLK];

    // cnt runs 15..46 in VERT, so the low five bits minus 15 give the step without wrap issues.
    assign j     = cnt[4:0] - 5'd15;
    assign sel_v = j[4:3];
    assign y     = j[2:0];

    assign next_row = (state == LOAD) ? {56'd0, cnt} : 64'd14;
    assign sel      = (state == VERT) ? {6'd0, sel_v} : 8'd0;

    // One window per output column, shared by the three phase filters of that column.
    always_comb begin
        win = '{default: '0};
        for (int x = 0; x < BLK; x++) begin
            for (int t = 0; t < TAPS; t++) begin
                if (state == LOAD) begin
                    win[x][PIX_W*t +: PIX_W] = in_row[PIX_W*(x+t) +: PIX_W];
                end else begin
                    case (sel_v)
                        2'd0: win[x][PIX_W*t +: PIX_W] = int_rows[ROW_W*(int'(y)+t) + PIX_W*x +: PIX_W];
                        2'd1: win[x][PIX_W*t +: PIX_W] = temp_A[ROW_W*(int'(y)+t) + PIX_W*x +: PIX_W];
                        2'd2: win[x][PIX_W*t +: PIX_W] = temp_B[ROW_W*(int'(y)+t) + PIX_W*x +: PIX_W];
                        2'd3: win[x][PIX_W*t +: PIX_W] = temp_C[ROW_W*(int'(y)+t) + PIX_W*x +: PIX_W];
                    endcase
                end
            end
        end
    end

    for (genvar x = 0; x < BLK; x++) begin : g_col
        subpel_fir8 u_fir_a (.window(win[x]), .phase(2'd0), .pix(fir_out_a[PIX_W*x +: PIX_W]));
        subpel_fir8 u_fir_b (.window(win[x]), .phase(2'd1), .pix(fir_out_b[PIX_W*x +: PIX_W]));
        subpel_fir8 u_fir_c (.window(win[x]), .phase(2'd2), .pix(fir_out_c[PIX_W*x +: PIX_W]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= LOAD;
            cnt           <= '0;
            out_A         <= '0;
            out_B         <= '0;
            out_C         <= '0;
            temp_A        <= '0;
            temp_B        <= '0;
            temp_C        <= '0;
            int_rows      <= '0;
            currentPixels <= '0;
            load_out      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    temp_A[ROW_W*cnt +: ROW_W]   <= fir_out_a;
                    temp_B[ROW_W*cnt +: ROW_W]   <= fir_out_b;
                    temp_C[ROW_W*cnt +: ROW_W]   <= fir_out_c;
                    int_rows[ROW_W*cnt +: ROW_W] <= in_row[3*PIX_W +: ROW_W];
                    currentPixels                <= in_row;
                    // Rows 3..10 are the block's own integer rows: their horizontal results are a/b/c.
                    if (cnt >= 8'd3 && cnt <= 8'd10) begin
                        out_A[ROW_W*(int'(cnt)-3) +: ROW_W] <= fir_out_a;
                        out_B[ROW_W*(int'(cnt)-3) +: ROW_W] <= fir_out_b;
                        out_C[ROW_W*(int'(cnt)-3) +: ROW_W] <= fir_out_c;
                    end
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'd14)
                        state <= VERT;
                end
                VERT: begin
                    case (sel_v)
                        2'd0: begin
                            out_A[ROW_W*(32+int'(y)) +: ROW_W] <= fir_out_a;
                            out_B[ROW_W*(32+int'(y)) +: ROW_W] <= fir_out_b;
                            out_C[ROW_W*(32+int'(y)) +: ROW_W] <= fir_out_c;
                        end
                        2'd1: begin
                            out_A[ROW_W*(8+int'(y))  +: ROW_W] <= fir_out_a;
                            out_A[ROW_W*(16+int'(y)) +: ROW_W] <= fir_out_b;
                            out_A[ROW_W*(24+int'(y)) +: ROW_W] <= fir_out_c;
                        end
                        2'd2: begin
                            out_B[ROW_W*(8+int'(y))  +: ROW_W] <= fir_out_a;
                            out_B[ROW_W*(16+int'(y)) +: ROW_W] <= fir_out_b;
                            out_B[ROW_W*(24+int'(y)) +: ROW_W] <= fir_out_c;
                        end
                        2'd3: begin
                            out_C[ROW_W*(8+int'(y))  +: ROW_W] <= fir_out_a;
                            out_C[ROW_W*(16+int'(y)) +: ROW_W] <= fir_out_b;
                            out_C[ROW_W*(24+int'(y)) +: ROW_W] <= fir_out_c;
                        end
                    endcase
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'd46)
                        state <= DONE;
                end
                default: begin
                    load_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subpel_interp_8x8.sv
// tb/tb_subpel_interp_8x8.sv - directed self-checking bench for subpel_interp_8x8
module tb_subpel_interp_8x8;

    logic           clk;
    logic           rst;
    logic [119:0]   in_row;
    logic [63:0]    next_row;
    logic [2559:0]  out_A, out_B, out_C;
    logic [7:0]     cnt;
    logic [63:0]    fir_out_a, fir_out_b, fir_out_c;
    logic [959:0]   temp_A, temp_B, temp_C;
    logic           load_out;
    logic [7:0]     sel;
    logic [119:0]   currentPixels;

    int             mode;
    logic [7:0]     fill;
    int             total;
    int             passed;
    logic [7:0]     ea [8];
    logic [7:0]     eb [8];
    logic [7:0]     ec [8];

    subpel_interp_8x8 dut (
        .clk(clk), .rst(rst), .in_row(in_row), .next_row(next_row),
        .out_A(out_A), .out_B(out_B), .out_C(out_C), .cnt(cnt),
        .fir_out_a(fir_out_a), .fir_out_b(fir_out_b), .fir_out_c(fir_out_c),
        .temp_A(temp_A), .temp_B(temp_B), .temp_C(temp_C),
        .load_out(load_out), .sel(sel), .currentPixels(currentPixels)
    );

    always #5 clk = ~clk;

    // Reference fetch buffer: 0 = flat fill, 1 = pixel 7 of every row is 64, 2 = only row 7 is 64.
    always_comb begin
        in_row = '0;
        case (mode)
            0: in_row = {15{fill}};
            1: in_row[56 +: 8] = 8'd64;
            2: in_row = (next_row == 64'd7) ? {15{8'd64}} : 120'd0;
            default: in_row = '0;
        endcase
    end

    function automatic logic [63:0] rw(input logic [2559:0] v, input int r);
        return v[64*r +: 64];
    endfunction

    function automatic logic [63:0] px(input logic [2559:0] v, input int r, input int x);
        return {56'd0, v[64*r + 8*x +: 8]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [2559:0] v, input logic [7:0] b);
        logic [2559:0] ev;
        int k;
        ev = {320{b}};
        total++;
        assert (v === ev) passed++;
        else begin
            k = 0;
            while (k < 39 && v[64*k +: 64] === ev[64*k +: 64]) k++;
            $error("FAIL %s row %0d observed=%h expected=%h", tag, k, v[64*k +: 64], ev[64*k +: 64]);
        end
    endtask

    task automatic start();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic step_run(input int n, input bit seq);
        logic [63:0] enr;
        logic [63:0] esel;
        for (int e = 0; e < n; e++) begin
            if (seq) begin
                enr  = (e < 14) ? 64'(e) : 64'd14;
                esel = (e >= 15 && e <= 46) ? 64'((e - 15) / 8) : 64'd0;
                chk($sformatf("next_row@%0d", e), next_row, enr);
                chk($sformatf("sel@%0d", e), {56'd0, sel}, esel);
                chk($sformatf("cnt@%0d", e), {56'd0, cnt}, 64'(e));
            end
            if (e == 47)
                chk("load_out_before_48th_edge", {63'd0, load_out}, 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_done();
        chk("load_out_done", {63'd0, load_out}, 64'd1);
        chk("cnt_done", {56'd0, cnt}, 64'd47);
    endtask

    task automatic chk_row7();
        chk("A_row3_int", rw(out_A, 3), 64'd0);
        chk("A_row4_int", rw(out_A, 4), {8{8'd64}});
        chk("C_row4_int", rw(out_C, 4), {8{8'd64}});
        for (int y = 0; y < 8; y++) begin
            chk($sformatf("A_e_row%0d", y), rw(out_A, 8+y),  {8{ea[y]}});
            chk($sformatf("A_i_row%0d", y), rw(out_A, 16+y), {8{eb[y]}});
            chk($sformatf("A_p_row%0d", y), rw(out_A, 24+y), {8{ec[y]}});
            chk($sformatf("B_f_row%0d", y), rw(out_B, 8+y),  {8{ea[y]}});
            chk($sformatf("B_j_row%0d", y), rw(out_B, 16+y), {8{eb[y]}});
            chk($sformatf("C_g_row%0d", y), rw(out_C, 8+y),  {8{ea[y]}});
            chk($sformatf("C_r_row%0d", y), rw(out_C, 24+y), {8{ec[y]}});
            chk($sformatf("A_d_row%0d", y), rw(out_A, 32+y), {8{ea[y]}});
            chk($sformatf("B_h_row%0d", y), rw(out_B, 32+y), {8{eb[y]}});
            chk($sformatf("C_n_row%0d", y), rw(out_C, 32+y), {8{ec[y]}});
        end
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b0;
        mode   = 0;
        fill   = 8'd0;
        total  = 0;
        passed = 0;
        // Clipped coefficient seen at window tap 7-y when only source row 7 carries 64.
        ea = '{8'd0, 8'd1, 8'd0, 8'd17, 8'd58, 8'd0, 8'd4, 8'd0};
        eb = '{8'd0, 8'd4, 8'd0, 8'd40, 8'd40, 8'd0, 8'd4, 8'd0};
        ec = '{8'd0, 8'd4, 8'd0, 8'd58, 8'd17, 8'd0, 8'd1, 8'd0};

        repeat (2) @(negedge clk);
        chk("reset_cnt", {56'd0, cnt}, 64'd0);
        chk("reset_next_row", next_row, 64'd0);
        chk("reset_load_out", {63'd0, load_out}, 64'd0);
        chk("reset_sel", {56'd0, sel}, 64'd0);

        // Flat zero, with full next_row/sel/cnt sequencing and load_out timing.
        mode = 0; fill = 8'd0;
        start();
        step_run(48, 1'b1);
        chk_done();
        chk_all("zero_A", out_A, 8'd0);
        chk_all("zero_B", out_B, 8'd0);
        chk_all("zero_C", out_C, 8'd0);

        // Flat 100: every filter reproduces a constant.
        mode = 0; fill = 8'd100;
        start();
        step_run(48, 1'b0);
        chk_done();
        chk_all("flat100_A", out_A, 8'h64);
        chk_all("flat100_B", out_B, 8'h64);
        chk_all("flat100_C", out_C, 8'h64);
        chk("flat100_currentPixels", currentPixels[63:0], {8{8'h64}});

        // Flat 255: no overflow or wrap at full scale.
        mode = 0; fill = 8'd255;
        start();
        step_run(48, 1'b0);
        chk_done();
        chk_all("flat255_A", out_A, 8'hFF);
        chk_all("flat255_B", out_B, 8'hFF);
        chk_all("flat255_C", out_C, 8'hFF);

        // Single bright column: horizontal impulse response and integer column offset.
        mode = 1;
        start();
        step_run(48, 1'b0);
        chk_done();
        chk("pix7_A_r0_x3", px(out_A, 0, 3), 64'd17);
        chk("pix7_A_r0_x4", px(out_A, 0, 4), 64'd58);
        chk("pix7_A_r0_x5", px(out_A, 0, 5), 64'd0);
        chk("pix7_B_r0_x3", px(out_B, 0, 3), 64'd40);
        chk("pix7_B_r0_x4", px(out_B, 0, 4), 64'd40);
        chk("pix7_B_r0_x5", px(out_B, 0, 5), 64'd0);
        chk("pix7_C_r0_x3", px(out_C, 0, 3), 64'd58);
        chk("pix7_C_r0_x4", px(out_C, 0, 4), 64'd17);
        chk("pix7_A_r7_x4", px(out_A, 7, 4), 64'd58);
        chk("pix7_A_e_r8_x3", px(out_A, 8, 3), 64'd17);
        chk("pix7_A_d_r32_x4", px(out_A, 32, 4), 64'd64);
        chk("pix7_A_d_r32_x3", px(out_A, 32, 3), 64'd0);

        // Single bright row, interrupted by reset at cnt=20, then rerun to completion.
        mode = 2;
        start();
        step_run(20, 1'b0);
        chk("mid_cnt_before_reset", {56'd0, cnt}, 64'd20);
        rst = 1'b0;
        #1;
        chk("mid_reset_cnt", {56'd0, cnt}, 64'd0);
        chk("mid_reset_next_row", next_row, 64'd0);
        chk("mid_reset_load_out", {63'd0, load_out}, 64'd0);
        chk_all("mid_reset_A", out_A, 8'd0);
        chk_all("mid_reset_B", out_B, 8'd0);
        start();
        step_run(48, 1'b1);
        chk_done();
        chk_row7();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
